// File: rtl/weight_buffer_loader_pkg.sv
// Shared constants and types for the weight buffer write-side loader.
//   - Buffer geometry (row address width, bank width, DDR beat width, bank count)
//   - LANES  : banks written by a single DDR beat
//   - GROUPS : beats needed to fill one buffer row
//   - GRP_W  : width of the group counter
//   - state_t: loader FSM encoding
//   - LANE_MASK: all-ones enable pattern for one lane group
package weight_loader_pkg;

  localparam int ADDR_LEN     = 16;
  localparam int DATA_LEN     = 64;
  localparam int DDR_DATA_LEN = 256;
  localparam int BUFFER_NUM   = 32;

  localparam int LANES  = DDR_DATA_LEN / DATA_LEN;
  localparam int GROUPS = BUFFER_NUM / LANES;
  localparam int GRP_W  = $clog2(GROUPS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [LANES-1:0] LANE_MASK = '1;

endpackage

// File: rtl/weight_buffer_loader_if.sv
// DDR beat stream between the read DMA and the weight buffer loader.
//   ddr_data  : one DDR beat
//   ddr_valid : beat present (driven by the DMA side)
//   ddr_ready : loader consumes the beat this cycle
// master = DMA side (produces beats), slave = loader side (consumes beats).
interface weight_buffer_loader_if;
  import weight_loader_pkg::*;

  logic [DDR_DATA_LEN-1:0] ddr_data;
  logic                    ddr_valid;
  logic                    ddr_ready;

  modport master (output ddr_data, output ddr_valid, input  ddr_ready);
  modport slave  (input  ddr_data, input  ddr_valid, output ddr_ready);

endinterface

// File: rtl/weight_buffer_loader.sv
// Weight buffer loader: turns a stream of DDR beats into buffer writes.
// Each accepted beat is written to one lane group (LANES banks) of the
// current row; after GROUPS beats the row address advances by one.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   cfg_start       : one-cycle start pulse, honoured only when idle
//   cfg_addr        : first row address of the load
//   cfg_rows        : number of rows to load (0 completes immediately)
//   ddr             : DDR beat stream (slave side)
//   data_wr         : buffer write data (replicated to every lane group)
//   wr_addr         : buffer write row address
//   wr_en           : per-bank write enables, one lane group at a time
//   busy            : load in progress
//   done            : one-cycle completion pulse, aligned with last write
module weight_buffer_loader
  import weight_loader_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cfg_start,
  input  logic [ADDR_LEN-1:0]     cfg_addr,
  input  logic [ADDR_LEN-1:0]     cfg_rows,
  weight_buffer_loader_if.slave   ddr,
  output logic [DDR_DATA_LEN-1:0] data_wr,
  output logic [ADDR_LEN-1:0]     wr_addr,
  output logic [BUFFER_NUM-1:0]   wr_en,
  output logic                    busy,
  output logic                    done
);

  state_t                state;
  logic [ADDR_LEN-1:0]   row_addr;
  logic [ADDR_LEN-1:0]   rows_left;
  logic [GRP_W-1:0]      grp;
  logic                  accept;
  logic [BUFFER_NUM-1:0] grp_en;

  assign ddr.ddr_ready = (state == LOAD);
  assign accept        = ddr.ddr_valid && (state == LOAD);
  assign busy          = (state != IDLE);
  assign done          = (state == DONE);

  // Bank b sits at bit b; a beat targets banks grp*LANES .. grp*LANES+LANES-1.
  assign grp_en = {{(BUFFER_NUM-LANES){1'b0}}, LANE_MASK} << (int'(grp) * LANES);

  // Stage boundary: accepted beat -> registered buffer write port (1-cycle latency)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      row_addr  <= '0;
      rows_left <= '0;
      grp       <= '0;
      data_wr   <= '0;
      wr_addr   <= '0;
      wr_en     <= '0;
    end else begin
      wr_en <= '0;
      case (state)
        IDLE: begin
          if (cfg_start) begin
            row_addr  <= cfg_addr;
            rows_left <= cfg_rows;
            grp       <= '0;
            state     <= (cfg_rows != '0) ? LOAD : DONE;
          end
        end
        LOAD: begin
          if (accept) begin
            data_wr <= ddr.ddr_data;
            wr_addr <= row_addr;
            wr_en   <= grp_en;
            if (grp == GRP_W'(GROUPS - 1)) begin
              grp       <= '0;
              row_addr  <= row_addr + ADDR_LEN'(1);
              rows_left <= rows_left - ADDR_LEN'(1);
              // Last group of the last row: the write lands together with done.
              if (rows_left == ADDR_LEN'(1)) state <= DONE;
            end else begin
              grp <= grp + GRP_W'(1);
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/weight_buffer_loader.md
Name: weight_buffer_loader

Overview:
- Write-side front end for the weight buffer. Accepts a stream of 256-bit DDR beats under a valid/ready handshake.
- Generates the buffer write port: `data_wr`, `wr_addr`, and the per-buffer `wr_en` bitmap.
- Each beat fills one lane group (DDR_DATA_LEN/DATA_LEN buffers) at the current row address. After the last group is written, the address advances one row.
- Sits between the DDR read DMA and the weight buffer. Configured per layer by the top-level controller.

Parameters:
- ADDR_LEN, 16, buffer row address width.
- DATA_LEN, 64, width of one buffer bank.
- DDR_DATA_LEN, 256, DDR beat width.
- BUFFER_NUM, 32, number of buffer banks (8*X_PE*X_MESH/DATA_LEN with X_PE=X_MESH=16).
- LANES, DDR_DATA_LEN/DATA_LEN (4), banks written per beat.
- GROUPS, BUFFER_NUM/LANES (8), beats per row.

Ports:
- clk, in, 1, clock.
- rst_n, in, 1, reset; asynchronous assert, active-low.
- cfg_start, in, 1, one-cycle pulse to begin a load; sampled only in IDLE.
- cfg_addr, in, ADDR_LEN, first row address; captured on cfg_start.
- cfg_rows, in, ADDR_LEN, number of rows to load; captured on cfg_start; 0 is legal.
- ddr_data, in, DDR_DATA_LEN, incoming beat.
- ddr_valid, in, 1, beat valid.
- ddr_ready, out, 1, loader accepts a beat this cycle.
- data_wr, out, DDR_DATA_LEN, write data to the buffer.
- wr_addr, out, ADDR_LEN, write row address.
- wr_en, out, BUFFER_NUM, bank write enables.
- busy, out, 1, load in progress.
- done, out, 1, one-cycle completion pulse.

Behaviour:
- Reset (asynchronous, any state including mid-load):
  - state=IDLE; ddr_ready=0; wr_en=0; data_wr=0; wr_addr=0; busy=0; done=0.
  - grp and row counters cleared.
  - Any partially written row is abandoned; no further writes occur.
- States:
  - IDLE: on cfg_start, capture cfg_addr into row_addr and cfg_rows into rows_left, set grp=0. Go to LOAD if cfg_rows!=0, else to DONE.
  - LOAD: ddr_ready=1 combinationally from state. A beat is accepted when ddr_valid && ddr_ready. On acceptance:
    - next-cycle outputs: data_wr<=ddr_data; wr_addr<=row_addr; wr_en<={LANES{1'b1}} << (grp*LANES).
    - if grp==GROUPS-1: grp<=0, row_addr<=row_addr+1 (mod 2^ADDR_LEN), rows_left<=rows_left-1. If rows_left==1, go to DONE.
    - else grp<=grp+1.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Write timing:
  - Write latency is 1 cycle: a beat accepted at cycle t drives wr_en/wr_addr/data_wr at t+1 for exactly one cycle.
  - wr_en=0 in every cycle that does not follow an accepted beat.
  - data_wr and wr_addr hold their last values when wr_en=0.
- Completion timing:
  - The final write appears in the same cycle done=1; done is never asserted before the last wr_en.
  - For cfg_rows=0, done asserts the cycle after cfg_start and no wr_en is ever asserted.
- busy = (state!=IDLE).
- ddr_ready is never 1 outside LOAD. Beats presented in IDLE or DONE are not consumed.
- cfg_start is ignored while busy; no re-capture occurs.
- Address wrap: row_addr rolls from 2^ADDR_LEN-1 to 0 with no error flag.
- Backpressure: gaps in ddr_valid stall grp and row counters without losing position.
- Enable placement: wr_en bit b maps to bank b. Bank b receives data_wr[(b%LANES)*DATA_LEN +: DATA_LEN], matching the buffer's replicated-dina wiring.
- Exactly LANES bits of wr_en are set per write.

Decomposition:
- Package weight_loader_pkg holds:
  - derived constants LANES and GROUPS;
  - GRP_W=$clog2(GROUPS);
  - the state encoding (IDLE, LOAD, DONE) as a 2-bit typedef;
  - the LANES-wide all-ones enable mask.
- No sub-module needed; the enable shifter is a single expression.
- Total RTL is roughly 150 lines.

Test Plan:
- Basic load: cfg_addr=0x0010, cfg_rows=1, 8 beats back-to-back with ddr_valid=1 -> wr_en = 0x0000000F, 0x000000F0, … 0xF0000000 on consecutive cycles, wr_addr=0x0010 throughout, data_wr matches each beat, done in the cycle of the 8th write, busy low the next cycle.
- Backpressure: cfg_rows=2, ddr_valid toggled 1-0-1-0 -> 16 writes total, row 0 at addr A, row 1 at addr A+1. No write occurs in a cycle after a non-accepted beat, and the group order is preserved.
- Wrap-around: cfg_addr=0xFFFF, cfg_rows=2 -> first 8 writes at 0xFFFF, next 8 at 0x0000, done once.
- Zero rows: cfg_rows=0 -> ddr_ready stays 0, wr_en never set, done pulses the cycle after cfg_start.
- Start while busy: second cfg_start with cfg_addr=0x0200 during a load at 0x0100 -> ignored; all writes at 0x0100 and onward; exactly one done.
- Reset mid-load: assert rst_n=0 after 3 beats of a 1-row load -> outputs immediately zero (asynchronous); after release, IDLE and ddr_ready=0. A new load of 1 row at 0x0005 completes normally with grp starting at 0 (wr_en=0x0000000F first).
